// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite responder over a word-addressed SRAM with independent read/write FSMs.
// Optional macro AXI_SRAM_RANDOM_DELAY_EN replaces the fixed latencies with LFSR-driven ones.
//
// Handshake rule (all five channels): a transfer happens on the rising clk edge
// where valid and ready are both high; a source holds its payload stable while
// valid is high and ready is low.
module axi_lite_sram_slave #(
   parameter int                ADDR_W        = 32,
   parameter int                DATA_W        = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR     = 32'h8000_0000,
   parameter int                MEM_WORDS     = 1024,
   parameter int                READ_LATENCY  = 1,
   parameter int                WRITE_LATENCY = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ADDR_W-1:0]   araddr,
   input  logic                arvalid,
   output logic                arready,
   output logic [DATA_W-1:0]   rdata,
   output logic [1:0]          rresp,
   output logic                rvalid,
   input  logic                rready,
   input  logic [ADDR_W-1:0]   awaddr,
   input  logic                awvalid,
   output logic                awready,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   input  logic                wvalid,
   output logic                wready,
   output logic [1:0]          bresp,
   output logic                bvalid,
   input  logic                bready,
   output logic [1:0]          o_dbg_rd_state,
   output logic [1:0]          o_dbg_wr_state
);

   localparam int              IDX_W  = $clog2(MEM_WORDS);
   localparam int              STRB_W = DATA_W / 8;
   localparam logic [ADDR_W:0] SPAN   = (ADDR_W + 1)'(MEM_WORDS) << 2;
   localparam logic [3:0]      RD_LAT = 4'(READ_LATENCY);
   localparam logic [3:0]      WR_LAT = 4'(WRITE_LATENCY);
   localparam logic [1:0]      RESP_OKAY   = 2'b00;
   localparam logic [1:0]      RESP_SLVERR = 2'b10;

   localparam logic [1:0] R_IDLE = 2'd0;
   localparam logic [1:0] R_WAIT = 2'd1;
   localparam logic [1:0] R_RESP = 2'd2;
   localparam logic [1:0] W_IDLE = 2'd0;
   localparam logic [1:0] W_WAIT = 2'd1;
   localparam logic [1:0] W_RESP = 2'd2;

   logic [DATA_W-1:0] r_mem [MEM_WORDS];

   logic [3:0] w_rd_lat;
   logic [3:0] w_wr_lat;

`ifdef AXI_SRAM_RANDOM_DELAY_EN
   logic [15:0] r_lfsr;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_lfsr <= 16'hACE1;
      end else begin
         r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      end
   end

   assign w_rd_lat = r_lfsr[3:0];
   assign w_wr_lat = r_lfsr[3:0];
`else
   assign w_rd_lat = RD_LAT;
   assign w_wr_lat = WR_LAT;
`endif

   // ---------------- read channel ----------------
   logic [1:0]        r_rd_state;
   logic [3:0]        r_rd_cnt;
   logic [ADDR_W-1:0] r_rd_addr;
   logic [DATA_W-1:0] r_rdata;
   logic [1:0]        r_rresp;

   logic              w_ar_hs;
   logic [ADDR_W-1:0] w_rd_sel_addr;
   logic [ADDR_W:0]   w_rd_off;
   logic              w_rd_hit;
   logic [IDX_W-1:0]  w_rd_idx;
   logic              w_rd_capture;

   assign arready       = (r_rd_state == R_IDLE);
   assign rvalid        = (r_rd_state == R_RESP);
   assign rdata         = r_rdata;
   assign rresp         = r_rresp;
   assign w_ar_hs       = arvalid && arready;
   // Zero latency captures straight from the bus in the handshake cycle.
   assign w_rd_sel_addr = (r_rd_state == R_IDLE) ? araddr : r_rd_addr;
   assign w_rd_off      = {1'b0, w_rd_sel_addr} - {1'b0, BASE_ADDR};
   assign w_rd_hit      = (w_rd_off < SPAN);
   assign w_rd_idx      = w_rd_off[IDX_W+1:2];
   assign w_rd_capture  = (w_ar_hs && (w_rd_lat == 4'd0)) ||
                          ((r_rd_state == R_WAIT) && (r_rd_cnt == 4'd1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_state <= R_IDLE;
         r_rd_cnt   <= 4'd0;
         r_rd_addr  <= '0;
         r_rdata    <= '0;
         r_rresp    <= RESP_OKAY;
      end else begin
         if (w_rd_capture) begin
            r_rdata <= w_rd_hit ? r_mem[w_rd_idx] : '0;
            r_rresp <= w_rd_hit ? RESP_OKAY : RESP_SLVERR;
         end
         case (r_rd_state)
            R_IDLE: begin
               if (w_ar_hs) begin
                  r_rd_addr  <= araddr;
                  r_rd_cnt   <= w_rd_lat;
                  r_rd_state <= (w_rd_lat == 4'd0) ? R_RESP : R_WAIT;
               end
            end
            R_WAIT: begin
               if (r_rd_cnt == 4'd1) begin
                  r_rd_state <= R_RESP;
               end else begin
                  r_rd_cnt <= r_rd_cnt - 4'd1;
               end
            end
            R_RESP: begin
               if (rready) begin
                  r_rd_state <= R_IDLE;
               end
            end
            default: r_rd_state <= R_IDLE;
         endcase
      end
   end

   // ---------------- write channel ----------------
   logic [1:0]        r_wr_state;
   logic [3:0]        r_wr_cnt;
   logic              r_aw_got;
   logic              r_w_got;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [DATA_W-1:0] r_wr_data;
   logic [STRB_W-1:0] r_wr_strb;
   logic [1:0]        r_bresp;

   logic              w_aw_hs;
   logic              w_w_hs;
   logic              w_wr_start;
   logic [ADDR_W-1:0] w_wr_sel_addr;
   logic [DATA_W-1:0] w_wr_sel_data;
   logic [STRB_W-1:0] w_wr_sel_strb;
   logic [ADDR_W:0]   w_wr_off;
   logic              w_wr_hit;
   logic [IDX_W-1:0]  w_wr_idx;
   logic              w_commit;

   assign awready       = (r_wr_state == W_IDLE) && !r_aw_got;
   assign wready        = (r_wr_state == W_IDLE) && !r_w_got;
   assign bvalid        = (r_wr_state == W_RESP);
   assign bresp         = r_bresp;
   assign w_aw_hs       = awvalid && awready;
   assign w_w_hs        = wvalid && wready;
   assign w_wr_start    = (r_wr_state == W_IDLE) &&
                          (r_aw_got || w_aw_hs) && (r_w_got || w_w_hs);
   assign w_wr_sel_addr = r_aw_got ? r_wr_addr : awaddr;
   assign w_wr_sel_data = r_w_got  ? r_wr_data : wdata;
   assign w_wr_sel_strb = r_w_got  ? r_wr_strb : wstrb;
   assign w_wr_off      = {1'b0, w_wr_sel_addr} - {1'b0, BASE_ADDR};
   assign w_wr_hit      = (w_wr_off < SPAN);
   assign w_wr_idx      = w_wr_off[IDX_W+1:2];
   assign w_commit      = !rst && ((w_wr_start && (w_wr_lat == 4'd0)) ||
                          ((r_wr_state == W_WAIT) && (r_wr_cnt == 4'd1)));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_state <= W_IDLE;
         r_wr_cnt   <= 4'd0;
         r_aw_got   <= 1'b0;
         r_w_got    <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_wr_strb  <= '0;
         r_bresp    <= RESP_OKAY;
      end else begin
         if (w_commit) begin
            r_bresp <= w_wr_hit ? RESP_OKAY : RESP_SLVERR;
         end
         case (r_wr_state)
            W_IDLE: begin
               if (w_aw_hs) begin
                  r_aw_got  <= 1'b1;
                  r_wr_addr <= awaddr;
               end
               if (w_w_hs) begin
                  r_w_got   <= 1'b1;
                  r_wr_data <= wdata;
                  r_wr_strb <= wstrb;
               end
               if (w_wr_start) begin
                  r_wr_cnt   <= w_wr_lat;
                  r_wr_state <= (w_wr_lat == 4'd0) ? W_RESP : W_WAIT;
               end
            end
            W_WAIT: begin
               if (r_wr_cnt == 4'd1) begin
                  r_wr_state <= W_RESP;
               end else begin
                  r_wr_cnt <= r_wr_cnt - 4'd1;
               end
            end
            W_RESP: begin
               if (bready) begin
                  r_wr_state <= W_IDLE;
                  r_aw_got   <= 1'b0;
                  r_w_got    <= 1'b0;
               end
            end
            default: r_wr_state <= W_IDLE;
         endcase
      end
   end

   // Read capture above sees the pre-write word when both hit the same edge.
   always_ff @(posedge clk) begin
      if (w_commit && w_wr_hit) begin
         for (int i = 0; i < STRB_W; i++) begin
            if (w_wr_sel_strb[i]) begin
               r_mem[w_wr_idx][8*i +: 8] <= w_wr_sel_data[8*i +: 8];
            end
         end
      end
   end

   assign o_dbg_rd_state = r_rd_state;
   assign o_dbg_wr_state = r_wr_state;

endmodule
